// File: rtl/melody_sequencer.sv
// Multi-voice step sequencer: shared playhead with programmable tempo, loop length
// and gate length, plus live recording of gate/degree into the current step.
module melody_sequencer #(
  parameter int STEPS     = 16,
  parameter int VOICES    = 2,
  parameter int DEG_WIDTH = 4,
  parameter int TDW       = 24,
  parameter int SW        = $clog2(STEPS),
  parameter int VW        = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          restart,
  input  logic [TDW-1:0]                tempo_div,
  input  logic [TDW-1:0]                gate_len,
  input  logic [SW:0]                   length,
  input  logic [VW-1:0]                 rec_voice,
  input  logic                          rec_set,
  input  logic                          rec_clear,
  input  logic [DEG_WIDTH-1:0]          rec_degree,
  output logic [SW-1:0]                 step_idx,
  output logic                          step_tick,
  output logic [VOICES-1:0]             gate,
  output logic [VOICES*DEG_WIDTH-1:0]   scale_degree
);

  localparam logic [SW:0] STEPS_W = (SW+1)'(STEPS);

  logic [STEPS-1:0]     pat_gate [VOICES];
  logic [DEG_WIDTH-1:0] pat_deg  [VOICES][STEPS];

  logic [TDW-1:0]       tick_cnt;
  logic [TDW-1:0]       tick_nxt;
  logic [SW-1:0]        step_nxt;
  logic [SW-1:0]        step_adv;
  logic                 tick_pulse;
  logic [SW:0]          eff_last;

  logic [VOICES-1:0]    wr_voice;
  logic                 wr_gate_val;
  logic                 wr_deg;

  logic                 sel_gate [VOICES];
  logic [DEG_WIDTH-1:0] sel_deg  [VOICES];
  logic [VOICES-1:0]    gate_nxt;
  logic [VOICES*DEG_WIDTH-1:0] deg_nxt;

  // Last active step index; out-of-range lengths fall back to the full pattern.
  always_comb begin
    if ((length == '0) || (length > STEPS_W))
      eff_last = STEPS_W - (SW+1)'(1);
    else
      eff_last = length - (SW+1)'(1);
  end

  assign step_adv = ({1'b0, step_idx} >= eff_last) ? '0 : step_idx + SW'(1);

  always_comb begin
    tick_nxt   = tick_cnt;
    step_nxt   = step_idx;
    tick_pulse = 1'b0;
    if (restart) begin
      tick_nxt = '0;
      step_nxt = '0;
    end else if (run) begin
      if (tick_cnt >= tempo_div) begin
        tick_nxt   = '0;
        step_nxt   = step_adv;
        tick_pulse = 1'b1;
      end else begin
        tick_nxt = tick_cnt + TDW'(1);
      end
    end
  end

  // Clear wins over set; a voice index with no matching voice writes nothing.
  assign wr_gate_val = ~rec_clear;
  assign wr_deg      = rec_set & ~rec_clear;

  always_comb begin
    wr_voice = '0;
    for (int v = 0; v < VOICES; v++)
      wr_voice[v] = (rec_set | rec_clear) && (rec_voice == VW'(v));
  end

  // Outputs are computed from the post-edge playhead and pattern, so a write
  // into the step being displayed is forwarded rather than shown one edge late.
  always_comb begin
    gate_nxt = '0;
    deg_nxt  = '0;
    for (int v = 0; v < VOICES; v++) begin
      sel_gate[v] = pat_gate[v][step_nxt];
      sel_deg[v]  = pat_deg[v][step_nxt];
      if (wr_voice[v] && (step_nxt == step_idx)) begin
        sel_gate[v] = wr_gate_val;
        if (wr_deg)
          sel_deg[v] = rec_degree;
      end
      gate_nxt[v] = run & sel_gate[v] & (tick_nxt < gate_len);
      deg_nxt[v*DEG_WIDTH +: DEG_WIDTH] = sel_deg[v];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt     <= '0;
      step_idx     <= '0;
      step_tick    <= 1'b0;
      gate         <= '0;
      scale_degree <= '0;
      for (int v = 0; v < VOICES; v++) begin
        pat_gate[v] <= '0;
        for (int s = 0; s < STEPS; s++)
          pat_deg[v][s] <= '0;
      end
    end else begin
      tick_cnt     <= tick_nxt;
      step_idx     <= step_nxt;
      step_tick    <= tick_pulse;
      gate         <= gate_nxt;
      scale_degree <= deg_nxt;
      for (int v = 0; v < VOICES; v++) begin
        if (wr_voice[v]) begin
          pat_gate[v][step_idx] <= wr_gate_val;
          if (wr_deg)
            pat_deg[v][step_idx] <= rec_degree;
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: tempo, recording, loop length, legato,
// pause/resume, restart and reset, with hand-computed expectations.
module tb_melody_sequencer;

  localparam int STEPS = 16;
  localparam int VOICES = 2;
  localparam int DW = 4;
  localparam int TDW = 24;
  localparam int SW = 4;
  localparam int VW = 1;

  logic             clk = 1'b0;
  logic             rst, run, restart;
  logic [TDW-1:0]   tempo_div, gate_len;
  logic [SW:0]      length;
  logic [VW-1:0]    rec_voice;
  logic             rec_set, rec_clear;
  logic [DW-1:0]    rec_degree;
  logic [SW-1:0]    step_idx;
  logic             step_tick;
  logic [VOICES-1:0] gate;
  logic [VOICES*DW-1:0] scale_degree;

  int checks = 0;
  int errors = 0;

  melody_sequencer #(.STEPS(STEPS), .VOICES(VOICES), .DEG_WIDTH(DW), .TDW(TDW)) dut (
    .clk(clk), .rst(rst), .run(run), .restart(restart),
    .tempo_div(tempo_div), .gate_len(gate_len), .length(length),
    .rec_voice(rec_voice), .rec_set(rec_set), .rec_clear(rec_clear),
    .rec_degree(rec_degree), .step_idx(step_idx), .step_tick(step_tick),
    .gate(gate), .scale_degree(scale_degree)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; run = 0; restart = 0; tempo_div = 0; gate_len = 0; length = 0;
    rec_voice = 0; rec_set = 0; rec_clear = 0; rec_degree = 0;
    cyc(); cyc();
    rst = 0;
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL reset_step got %0d want 0", step_idx); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %0b want 0", step_tick); end
    checks++; if (gate !== 2'b00) begin errors++; $display("FAIL reset_gate got %b want 00", gate); end
    checks++; if (scale_degree !== 8'h00) begin errors++; $display("FAIL reset_deg got %h want 00", scale_degree); end
  endtask

  task automatic test_tempo();
    logic [3:0] es;
    logic et;
    run = 1; tempo_div = 3; length = 0; gate_len = 0;
    for (int k = 1; k <= 64; k++) begin
      cyc();
      es = 4'((k / 4) % 16);
      et = (k % 4) == 0;
      checks++; if (step_idx !== es) begin errors++; $display("FAIL tempo_step k=%0d got %0d want %0d", k, step_idx, es); end
      checks++; if (step_tick !== et) begin errors++; $display("FAIL tempo_tick k=%0d got %0b want %0b", k, step_tick, et); end
      checks++; if (gate !== 2'b00) begin errors++; $display("FAIL tempo_gate k=%0d got %b want 00", k, gate); end
    end
  endtask

  task automatic test_record();
    logic [1:0] eg;
    logic [7:0] ed;
    int st, tk;
    for (int k = 0; k < 8; k++) cyc();
    run = 0;
    checks++; if (step_idx !== 4'd2) begin errors++; $display("FAIL rec_at_step got %0d want 2", step_idx); end
    rec_voice = 1; rec_degree = 5; rec_set = 1;
    cyc();
    rec_set = 0;
    checks++; if (scale_degree !== 8'h50) begin errors++; $display("FAIL rec_fwd_deg got %h want 50", scale_degree); end
    checks++; if (gate !== 2'b00) begin errors++; $display("FAIL rec_paused_gate got %b want 00", gate); end
    restart = 1;
    cyc();
    restart = 0;
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL rec_restart_step got %0d want 0", step_idx); end
    checks++; if (scale_degree !== 8'h00) begin errors++; $display("FAIL rec_restart_deg got %h want 00", scale_degree); end
    gate_len = 2; run = 1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      st = k / 4; tk = k % 4;
      eg = (st == 2 && tk < 2) ? 2'b10 : 2'b00;
      ed = (st == 2) ? 8'h50 : 8'h00;
      checks++; if (gate !== eg) begin errors++; $display("FAIL rec_play_gate k=%0d got %b want %b", k, gate, eg); end
      checks++; if (scale_degree !== ed) begin errors++; $display("FAIL rec_play_deg k=%0d got %h want %h", k, scale_degree, ed); end
    end
  endtask

  task automatic test_length();
    logic [3:0] es;
    logic [1:0] eg;
    logic [7:0] ed;
    int st, tk;
    run = 0; restart = 1;
    cyc();
    restart = 0;
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL len_restart got %0d want 0", step_idx); end
    tempo_div = 0; length = 5; gate_len = 2; run = 1; rec_voice = 0; rec_set = 1;
    for (int i = 0; i < 5; i++) begin
      rec_degree = 4'(i + 1);
      cyc();
      es = 4'((i + 1) % 5);
      checks++; if (step_idx !== es) begin errors++; $display("FAIL len_rec_step i=%0d got %0d want %0d", i, step_idx, es); end
    end
    rec_set = 0;
    checks++; if (gate !== 2'b01) begin errors++; $display("FAIL len_wrap_gate got %b want 01", gate); end
    checks++; if (scale_degree !== 8'h01) begin errors++; $display("FAIL len_wrap_deg got %h want 01", scale_degree); end
    tempo_div = 1; gate_len = 1;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      tk = k % 2; st = (k / 2) % 5;
      es = 4'(st);
      eg = {(st == 2 && tk == 0), (tk == 0)};
      ed = {((st == 2) ? 4'd5 : 4'd0), 4'(st + 1)};
      checks++; if (step_idx !== es) begin errors++; $display("FAIL len_play_step k=%0d got %0d want %0d", k, step_idx, es); end
      checks++; if (gate !== eg) begin errors++; $display("FAIL len_play_gate k=%0d got %b want %b", k, gate, eg); end
      checks++; if (scale_degree !== ed) begin errors++; $display("FAIL len_play_deg k=%0d got %h want %h", k, scale_degree, ed); end
    end
    for (int k = 0; k < 8; k++) cyc();
    length = 3;
    cyc();
    checks++; if (step_idx !== 4'd4) begin errors++; $display("FAIL len_shrink_hold got %0d want 4", step_idx); end
    cyc();
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL len_shrink_wrap got %0d want 0", step_idx); end
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL len_shrink_tick got %0b want 1", step_tick); end
    for (int k = 0; k < 6; k++) cyc();
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL len_three_loop got %0d want 0", step_idx); end
  endtask

  task automatic test_clear_legato();
    logic [1:0] eg [5];
    logic [3:0] es [5];
    eg[0] = 2'b11; eg[1] = 2'b11; eg[2] = 2'b01; eg[3] = 2'b01; eg[4] = 2'b00;
    es[0] = 4'd2;  es[1] = 4'd2;  es[2] = 4'd0;  es[3] = 4'd0;  es[4] = 4'd1;
    cyc(); cyc();
    run = 0; rec_voice = 0; rec_set = 1; rec_clear = 1; rec_degree = 9;
    cyc();
    rec_set = 0; rec_clear = 0;
    checks++; if (step_idx !== 4'd1) begin errors++; $display("FAIL clr_step got %0d want 1", step_idx); end
    checks++; if (scale_degree !== 8'h02) begin errors++; $display("FAIL clr_deg_kept got %h want 02", scale_degree); end
    gate_len = 2; run = 1;
    cyc();
    checks++; if (gate !== 2'b00) begin errors++; $display("FAIL clr_gate got %b want 00", gate); end
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (step_idx !== es[k]) begin errors++; $display("FAIL legato_step k=%0d got %0d want %0d", k, step_idx, es[k]); end
      checks++; if (gate !== eg[k]) begin errors++; $display("FAIL legato_gate k=%0d got %b want %b", k, gate, eg[k]); end
    end
  endtask

  task automatic test_pause();
    tempo_div = 5; gate_len = 4;
    for (int k = 0; k < 6; k++) cyc();
    checks++; if (step_idx !== 4'd2) begin errors++; $display("FAIL pause_pre_step got %0d want 2", step_idx); end
    checks++; if (step_tick !== 1'b1) begin errors++; $display("FAIL pause_pre_tick got %0b want 1", step_tick); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++; if (gate !== 2'b11) begin errors++; $display("FAIL pause_run_gate k=%0d got %b want 11", k, gate); end
    end
    run = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      checks++; if (gate !== 2'b00) begin errors++; $display("FAIL pause_gate k=%0d got %b want 00", k, gate); end
      checks++; if (step_idx !== 4'd2) begin errors++; $display("FAIL pause_step k=%0d got %0d want 2", k, step_idx); end
      checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL pause_tick k=%0d got %0b want 0", k, step_tick); end
    end
    run = 1;
    cyc();
    checks++; if (gate !== 2'b11) begin errors++; $display("FAIL resume_t3_gate got %b want 11", gate); end
    cyc();
    checks++; if (gate !== 2'b00) begin errors++; $display("FAIL resume_t4_gate got %b want 00", gate); end
    cyc();
    checks++; if (step_tick !== 1'b0 || step_idx !== 4'd2) begin errors++; $display("FAIL resume_t5 got step %0d tick %0b want step 2 tick 0", step_idx, step_tick); end
    cyc();
    checks++; if (step_idx !== 4'd0 || step_tick !== 1'b1) begin errors++; $display("FAIL resume_adv got step %0d tick %0b want step 0 tick 1", step_idx, step_tick); end
    checks++; if (gate !== 2'b01) begin errors++; $display("FAIL resume_adv_gate got %b want 01", gate); end
  endtask

  task automatic test_restart_rst();
    logic [3:0] es;
    for (int k = 0; k < 8; k++) cyc();
    checks++; if (step_idx !== 4'd1) begin errors++; $display("FAIL rs_pre_step got %0d want 1", step_idx); end
    restart = 1;
    cyc();
    restart = 0;
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL rs_restart_step got %0d want 0", step_idx); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rs_restart_tick got %0b want 0", step_tick); end
    checks++; if (gate !== 2'b01) begin errors++; $display("FAIL rs_restart_gate got %b want 01", gate); end
    cyc(); cyc();
    rst = 1;
    cyc();
    rst = 0;
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL rs_rst_step got %0d want 0", step_idx); end
    checks++; if (gate !== 2'b00) begin errors++; $display("FAIL rs_rst_gate got %b want 00", gate); end
    checks++; if (scale_degree !== 8'h00) begin errors++; $display("FAIL rs_rst_deg got %h want 00", scale_degree); end
    checks++; if (step_tick !== 1'b0) begin errors++; $display("FAIL rs_rst_tick got %0b want 0", step_tick); end
    tempo_div = 0; length = 0; gate_len = 4;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      es = 4'(k % 16);
      checks++; if (step_idx !== es) begin errors++; $display("FAIL rs_scan_step k=%0d got %0d want %0d", k, step_idx, es); end
      checks++; if (gate !== 2'b00) begin errors++; $display("FAIL rs_scan_gate k=%0d got %b want 00", k, gate); end
      checks++; if (scale_degree !== 8'h00) begin errors++; $display("FAIL rs_scan_deg k=%0d got %h want 00", k, scale_degree); end
    end
  endtask

  initial begin
    test_reset();
    test_tempo();
    test_record();
    test_length();
    test_clear_legato();
    test_pause();
    test_restart_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
